// File: rtl/md_pkg.sv
// Shared types and widths for the Magical Dartboard throw scheduler.
package md_pkg;

  localparam int unsigned MD_BOARD_SIZE = 16;
  localparam int unsigned MD_SCORE_W    = 3;
  localparam int unsigned MD_DART_W     = $clog2(MD_BOARD_SIZE);
  localparam int unsigned MD_ROT_W      = 3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ARB    = 3'd1,
    ST_ISSUE  = 3'd2,
    ST_WAIT   = 3'd3,
    ST_REPORT = 3'd4
  } md_state_e;

  // Throw command forwarded to the scoring engine
  typedef struct packed {
    logic [MD_DART_W-1:0] dart;
    logic [MD_ROT_W-1:0]  rot;
    logic                 flag;
  } md_cmd_t;

endpackage

// File: rtl/md_rr_arbiter.sv
// Combinational round-robin select: first eligible requester at or after ptr,
// wrapping modulo N.
module md_rr_arbiter #(
  parameter int unsigned N   = 4,
  parameter int unsigned IDW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]   elig,
  input  logic [IDW-1:0] ptr,
  output logic [N-1:0]   gnt_c,
  output logic [IDW-1:0] idx_c,
  output logic           found_c
);

  int j;

  // Scan offsets from far to near so the nearest eligible player wins last.
  always_comb begin
    gnt_c   = '0;
    idx_c   = '0;
    found_c = 1'b0;
    j       = 0;
    for (int k = int'(N) - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= int'(N)) j = j - int'(N);
      if (elig[j]) begin
        found_c  = 1'b1;
        idx_c    = IDW'(j);
        gnt_c    = '0;
        gnt_c[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/md_throw_sched.sv
// Round-robin throw scheduler sharing one dartboard scoring engine among
// NPLAYER players; accumulates saturating totals and streams them at game end.
module md_throw_sched
  import md_pkg::*;
#(
  parameter int unsigned NPLAYER = 4,
  parameter int unsigned THROWS  = 3,
  parameter int unsigned SUMW    = 7
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic [NPLAYER-1:0]             req,
  input  logic [MD_DART_W*NPLAYER-1:0]   dart_in,
  input  logic [MD_ROT_W*NPLAYER-1:0]    rot_in,
  input  logic [NPLAYER-1:0]             flag_in,
  output logic [NPLAYER-1:0]             gnt,
  output logic                           eng_valid,
  output logic [MD_DART_W-1:0]           eng_dart,
  output logic [MD_ROT_W-1:0]            eng_rot,
  output logic                           eng_flag,
  input  logic                           eng_ready,
  input  logic                           eng_done,
  input  logic [MD_SCORE_W-1:0]          eng_score,
  output logic                           busy,
  output logic                           out_valid,
  output logic [$clog2(NPLAYER)-1:0]     out_id,
  output logic [SUMW-1:0]                out_sum
);

  localparam int unsigned IDW  = $clog2(NPLAYER);
  localparam int unsigned CNTW = $clog2(THROWS + 1);

  md_state_e            state_q, state_d;
  md_cmd_t              cmd_q, cmd_d;
  logic [IDW-1:0]       cur_q, cur_d;
  logic [IDW-1:0]       ptr_q, ptr_d;
  logic [CNTW-1:0]      cnt_q   [NPLAYER];
  logic [CNTW-1:0]      cnt_d   [NPLAYER];
  logic [SUMW-1:0]      total_q [NPLAYER];
  logic [SUMW-1:0]      total_d [NPLAYER];
  logic [NPLAYER-1:0]   gnt_q, gnt_d;
  logic                 eng_valid_q, eng_valid_d;
  logic                 busy_q, busy_d;
  logic                 out_valid_q, out_valid_d;
  logic [IDW-1:0]       out_id_q, out_id_d;
  logic [SUMW-1:0]      out_sum_q, out_sum_d;

  logic [NPLAYER-1:0]   elig_c;
  logic                 all_done_c;
  logic [NPLAYER-1:0]   arb_gnt_c;
  logic [IDW-1:0]       arb_idx_c;
  logic                 arb_found_c;
  logic [SUMW:0]        sum_c;
  logic [SUMW-1:0]      sat_c;

  // Players that still owe throws and are requesting
  always_comb begin
    elig_c     = '0;
    all_done_c = 1'b1;
    for (int p = 0; p < int'(NPLAYER); p++) begin
      elig_c[p] = req[p] && (cnt_q[p] < CNTW'(THROWS));
      if (cnt_q[p] != CNTW'(THROWS)) all_done_c = 1'b0;
    end
  end

  md_rr_arbiter #(
    .N   (NPLAYER),
    .IDW (IDW)
  ) u_arb (
    .elig    (elig_c),
    .ptr     (ptr_q),
    .gnt_c   (arb_gnt_c),
    .idx_c   (arb_idx_c),
    .found_c (arb_found_c)
  );

  // Total update is widened by one bit so overflow is visible before clamping.
  always_comb begin
    sum_c = {1'b0, total_q[cur_q]} + (SUMW+1)'(eng_score);
    sat_c = sum_c[SUMW] ? {SUMW{1'b1}} : sum_c[SUMW-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cmd_q       <= '0;
      cur_q       <= '0;
      ptr_q       <= '0;
      gnt_q       <= '0;
      eng_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_id_q    <= '0;
      out_sum_q   <= '0;
      for (int p = 0; p < int'(NPLAYER); p++) begin
        cnt_q[p]   <= '0;
        total_q[p] <= '0;
      end
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      cur_q       <= cur_d;
      ptr_q       <= ptr_d;
      gnt_q       <= gnt_d;
      eng_valid_q <= eng_valid_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      out_id_q    <= out_id_d;
      out_sum_q   <= out_sum_d;
      for (int p = 0; p < int'(NPLAYER); p++) begin
        cnt_q[p]   <= cnt_d[p];
        total_q[p] <= total_d[p];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start) state_d = ST_ARB;
      ST_ARB: begin
        if (arb_found_c)     state_d = ST_ISSUE;
        else if (all_done_c) state_d = ST_REPORT;
      end
      ST_ISSUE:  if (eng_ready) state_d = ST_WAIT;
      ST_WAIT:   if (eng_done) state_d = ST_ARB;
      ST_REPORT: if (out_id_q == IDW'(NPLAYER - 1)) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Registered outputs track the state being entered, so they align with it.
  always_comb begin
    cmd_d       = cmd_q;
    cur_d       = cur_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    total_d     = total_q;
    gnt_d       = '0;
    eng_valid_d = (state_d == ST_ISSUE);
    busy_d      = (state_d != ST_IDLE);
    out_valid_d = 1'b0;
    out_id_d    = '0;
    out_sum_d   = '0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          ptr_d = '0;
          for (int p = 0; p < int'(NPLAYER); p++) begin
            cnt_d[p]   = '0;
            total_d[p] = '0;
          end
        end
      end
      ST_ARB: begin
        if (arb_found_c) begin
          gnt_d = arb_gnt_c;
          cur_d = arb_idx_c;
          for (int p = 0; p < int'(NPLAYER); p++) begin
            if (arb_gnt_c[p]) begin
              cmd_d.dart = dart_in[p*MD_DART_W +: MD_DART_W];
              cmd_d.rot  = rot_in[p*MD_ROT_W +: MD_ROT_W];
              cmd_d.flag = flag_in[p];
            end
          end
        end else if (all_done_c) begin
          out_valid_d = 1'b1;
          out_sum_d   = total_q[0];
        end
      end
      ST_WAIT: begin
        if (eng_done) begin
          total_d[cur_q] = sat_c;
          cnt_d[cur_q]   = cnt_q[cur_q] + CNTW'(1);
          ptr_d          = (cur_q == IDW'(NPLAYER - 1)) ? '0 : cur_q + IDW'(1);
        end
      end
      ST_REPORT: begin
        if (state_d == ST_REPORT) begin
          out_valid_d = 1'b1;
          out_id_d    = out_id_q + IDW'(1);
          out_sum_d   = total_q[out_id_d];
        end
      end
      default: ;
    endcase
  end

  assign gnt       = gnt_q;
  assign eng_valid = eng_valid_q;
  assign eng_dart  = cmd_q.dart;
  assign eng_rot   = cmd_q.rot;
  assign eng_flag  = cmd_q.flag;
  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign out_id    = out_id_q;
  assign out_sum   = out_sum_q;

endmodule

// File: tb/tb_md_throw_sched.sv
// Directed bench for md_throw_sched: a scripted engine serves each throw and
// the report stream is checked against hand-computed totals.
module tb_md_throw_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [3:0]  req;
  logic [15:0] dart_in;
  logic [11:0] rot_in;
  logic [3:0]  flag_in;
  logic        eng_ready;
  logic        eng_done;
  logic [2:0]  eng_score;

  logic [3:0]  gnt, s_gnt;
  logic        eng_valid, s_eng_valid;
  logic [3:0]  eng_dart, s_eng_dart;
  logic [2:0]  eng_rot, s_eng_rot;
  logic        eng_flag, s_eng_flag;
  logic        busy, s_busy;
  logic        out_valid, s_out_valid;
  logic [1:0]  out_id, s_out_id;
  logic [6:0]  out_sum;
  logic [3:0]  s_out_sum;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  md_throw_sched #(.NPLAYER(4), .THROWS(3), .SUMW(7)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .req(req),
    .dart_in(dart_in), .rot_in(rot_in), .flag_in(flag_in),
    .gnt(gnt), .eng_valid(eng_valid), .eng_dart(eng_dart),
    .eng_rot(eng_rot), .eng_flag(eng_flag), .eng_ready(eng_ready),
    .eng_done(eng_done), .eng_score(eng_score), .busy(busy),
    .out_valid(out_valid), .out_id(out_id), .out_sum(out_sum)
  );

  // Narrow-total instance shares the stimulus to exercise saturation.
  md_throw_sched #(.NPLAYER(4), .THROWS(3), .SUMW(4)) u_sat (
    .clk(clk), .rst_n(rst_n), .start(start), .req(req),
    .dart_in(dart_in), .rot_in(rot_in), .flag_in(flag_in),
    .gnt(s_gnt), .eng_valid(s_eng_valid), .eng_dart(s_eng_dart),
    .eng_rot(s_eng_rot), .eng_flag(s_eng_flag), .eng_ready(eng_ready),
    .eng_done(eng_done), .eng_score(eng_score), .busy(s_busy),
    .out_valid(s_out_valid), .out_id(s_out_id), .out_sum(s_out_sum)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int min15(input int v);
    return (v > 15) ? 15 : v;
  endfunction

  task automatic start_game();
    start = 1'b1;
    tick();
    start = 1'b0;
    check_eq("busy_start", 32'(busy), 32'd1);
  endtask

  // Waits for a grant; one-shot stimulus pulses are dropped after each edge.
  task automatic wait_gnt(output int who, output int waited);
    who    = -1;
    waited = 0;
    while (who < 0 && waited < 40) begin
      tick();
      waited++;
      start     = 1'b0;
      eng_done  = 1'b0;
      eng_score = 3'd0;
      for (int p = 0; p < 4; p++) if (gnt[p]) who = p;
    end
    if (who < 0) check_eq("gnt_timeout", 32'd0, 32'd1);
  endtask

  task automatic serve(input int p, input int score, input int stall, input bit poke);
    int who;
    int waited;
    if (poke) begin
      start     = 1'b1;
      eng_done  = 1'b1;
      eng_score = 3'd7;
    end
    wait_gnt(who, waited);
    check_eq("gnt_lat",  32'(waited), 32'd1);
    check_eq("gnt_who",  32'(who), 32'(p));
    check_eq("gnt_vec",  32'(gnt), 32'(1 << p));
    check_eq("valid_up", 32'(eng_valid), 32'd1);
    check_eq("eng_dart", 32'(eng_dart), 32'(3 * p + 1));
    check_eq("eng_rot",  32'(eng_rot), 32'(p + 2));
    check_eq("eng_flag", 32'(eng_flag), 32'(p % 2));
    for (int s = 0; s < stall; s++) begin
      tick();
      check_eq("stall_valid", 32'(eng_valid), 32'd1);
      check_eq("stall_gnt",   32'(gnt), 32'd0);
      check_eq("stall_dart",  32'(eng_dart), 32'(3 * p + 1));
      check_eq("stall_rot",   32'(eng_rot), 32'(p + 2));
      check_eq("stall_flag",  32'(eng_flag), 32'(p % 2));
    end
    eng_ready = 1'b1;
    tick();
    eng_ready = 1'b0;
    check_eq("valid_drop", 32'(eng_valid), 32'd0);
    eng_done  = 1'b1;
    eng_score = 3'(score);
    tick();
    eng_done  = 1'b0;
    eng_score = 3'd0;
  endtask

  task automatic collect_report(input int e0, input int e1, input int e2, input int e3);
    int e[4];
    int w;
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
    w = 0;
    while (!out_valid && w < 20) begin
      tick();
      w++;
    end
    check_eq("rpt_lat", 32'(w), 32'd1);
    for (int k = 0; k < 4; k++) begin
      check_eq("rpt_valid",   32'(out_valid), 32'd1);
      check_eq("rpt_id",      32'(out_id), 32'(k));
      check_eq("rpt_sum",     32'(out_sum), 32'(e[k]));
      check_eq("rpt_s_valid", 32'(s_out_valid), 32'd1);
      check_eq("rpt_s_id",    32'(s_out_id), 32'(k));
      check_eq("rpt_s_sum",   32'(s_out_sum), 32'(min15(e[k])));
      tick();
    end
    check_eq("rpt_end_valid", 32'(out_valid), 32'd0);
    check_eq("rpt_end_busy",  32'(busy), 32'd0);
  endtask

  initial begin
    int who;
    int waited;
    bit seen_bad;
    rst_n     = 1'b0;
    start     = 1'b0;
    req       = 4'd0;
    eng_ready = 1'b0;
    eng_done  = 1'b0;
    eng_score = 3'd0;
    for (int p = 0; p < 4; p++) begin
      dart_in[4*p +: 4] = 4'(3 * p + 1);
      rot_in[3*p +: 3]  = 3'(p + 2);
      flag_in[p]        = p[0];
    end
    repeat (3) tick();
    check_eq("rst_gnt",   32'(gnt), 32'd0);
    check_eq("rst_valid", 32'(eng_valid), 32'd0);
    check_eq("rst_busy",  32'(busy), 32'd0);
    check_eq("rst_oval",  32'(out_valid), 32'd0);
    check_eq("rst_osum",  32'(out_sum), 32'd0);
    rst_n = 1'b1;
    tick();

    // Single requester finishes alone; no report until everyone is done
    req = 4'b0100;
    start_game();
    serve(2, 5, 0, 1'b0);
    serve(2, 3, 0, 1'b0);
    serve(2, 7, 0, 1'b0);
    seen_bad = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (gnt != 4'd0 || out_valid) seen_bad = 1'b1;
    end
    check_eq("solo_no_report", 32'(seen_bad), 32'd0);
    check_eq("solo_busy",      32'(busy), 32'd1);
    req = 4'b1111;
    for (int r = 0; r < 3; r++) begin
      serve(3, 1, 0, 1'b0);
      serve(0, 1, 0, 1'b0);
      serve(1, 1, 0, 1'b0);
    end
    collect_report(3, 3, 15, 3);

    // All requesting, with ready stall and ignored start / stray done
    req = 4'b1111;
    start_game();
    for (int r = 0; r < 3; r++) begin
      for (int p = 0; p < 4; p++) begin
        serve(p, 2, (r == 1 && p == 1) ? 5 : 0, (r == 1 && p == 0));
      end
    end
    collect_report(6, 6, 6, 6);

    // Saturation: player 0 scores 7 three times
    start_game();
    for (int r = 0; r < 3; r++) begin
      serve(0, 7, 0, 1'b0);
      serve(1, 0, 0, 1'b0);
      serve(2, 0, 0, 1'b0);
      serve(3, 0, 0, 1'b0);
    end
    collect_report(21, 0, 0, 0);

    // Reset while waiting on the engine, then a clean replay
    start_game();
    serve(0, 4, 0, 1'b0);
    wait_gnt(who, waited);
    check_eq("mid_who", 32'(who), 32'd1);
    eng_ready = 1'b1;
    tick();
    eng_ready = 1'b0;
    check_eq("mid_wait_valid", 32'(eng_valid), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_busy",  32'(busy), 32'd0);
    check_eq("arst_gnt",   32'(gnt), 32'd0);
    check_eq("arst_valid", 32'(eng_valid), 32'd0);
    check_eq("arst_dart",  32'(eng_dart), 32'd0);
    check_eq("arst_rot",   32'(eng_rot), 32'd0);
    check_eq("arst_flag",  32'(eng_flag), 32'd0);
    check_eq("arst_oval",  32'(out_valid), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check_eq("post_rst_busy", 32'(busy), 32'd0);
    start_game();
    for (int r = 0; r < 3; r++) begin
      for (int p = 0; p < 4; p++) serve(p, 1, 0, 1'b0);
    end
    collect_report(3, 3, 3, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/md_throw_sched.md
# md_throw_sched

Round-robin throw scheduler that shares one Magical Dartboard scoring engine among `NPLAYER` requesting players for a fixed-length game. It grants one throw at a time, forwards the winner's dart and rotation command to the engine over a valid/ready handshake, and accumulates each player's returned score. When the game ends it streams the per-player totals. It sits between the player-input front end and the dartboard engine, which is preloaded with its 16 scores before `start`.

## Interface
- `NPLAYER`, 4, number of requesting players (2..8)
- `THROWS`, 3, throws per player per game (1..15)
- `SUMW`, 7, per-player total width
- `clk` in 1: clock, rising edge
- `rst_n` in 1: reset, asynchronous, active-low
- `start` in 1: one-cycle game-start pulse; honoured only in IDLE
- `req` in NPLAYER: per-player throw request; held until that player's `gnt`
- `dart_in` in 4*NPLAYER: player p's dart position in bits [4p+3:4p]; bit 3 selects outer ring
- `rot_in` in 3*NPLAYER: player p's rotation step in bits [3p+2:3p]; 0 means swap rings
- `flag_in` in NPLAYER: per-player rotation direction; 1 means counter-clockwise
- `gnt` out NPLAYER: one-hot grant, one-cycle pulse
- `eng_valid` out 1: throw command valid to engine
- `eng_dart` out 4, `eng_rot` out 3, `eng_flag` out 1: captured command fields
- `eng_ready` in 1: engine accepts the command when `eng_valid & eng_ready`
- `eng_done` in 1: one-cycle pulse; `eng_score` is valid in the same cycle
- `eng_score` in 3: points scored by the throw
- `busy` out 1: high in every state except IDLE
- `out_valid` out 1: total-report strobe
- `out_id` out clog2(NPLAYER): player index of the reported total
- `out_sum` out SUMW: reported total

## Operation
- **States:** IDLE, ARB, ISSUE, WAIT, REPORT.
- **IDLE:**
  - On `start`: clear all totals and throw counters, set the round-robin pointer to 0, go to ARB.
- **ARB:**
  - Eligible player: `req[p]=1` and `cnt[p] < THROWS`.
  - Select the first eligible p at or after the pointer, wrapping modulo `NPLAYER`.
  - If a player is selected: capture its dart, rotation and flag fields and `p`, then go to ISSUE.
  - Else if every `cnt == THROWS`: go to REPORT.
  - Else: stay in ARB.
- **ISSUE:**
  - `eng_valid=1` with the captured fields held stable.
  - On `eng_ready`: go to WAIT.
- **WAIT:**
  - On `eng_done`: `total[p] += eng_score`, saturating at 2^SUMW-1.
  - Also `cnt[p]++` and pointer = (p+1) mod `NPLAYER`.
  - Then go to ARB.
- **REPORT:**
  - Emit `NPLAYER` consecutive `out_valid` cycles with `out_id` = 0,1,...,N-1 and `out_sum` = total[out_id].
  - Then go to IDLE.
- **Ignored events:**
  - `start` outside IDLE.
  - `eng_done` outside WAIT.
  - `req` from a player that has finished its throws (never granted again).
- **Width rule:** sums are computed in SUMW+1 bits, then saturated.

## Timing
- **Registered outputs:** all outputs are registered, and every output resets to 0.
- **gnt:** pulses for the single cycle in which ISSUE is entered; it coincides with the first `eng_valid` cycle.
- **Start latency:** `start` sampled at edge 0 leads to ARB in cycle 1. With a request pending, `gnt` and `eng_valid` are high in cycle 2.
- **Minimum throw:** 3 cycles (ARB, ISSUE with `eng_ready` already high, WAIT with `eng_done` in the next cycle).
- **Same-cycle `eng_ready` and `eng_done`:** `eng_done` is not sampled in ISSUE. The engine must pulse `eng_done` no earlier than the cycle after the handshake.
- **REPORT timing:** `out_valid` rises in the cycle after the last WAIT→ARB→REPORT decision and stays high for exactly `NPLAYER` cycles. `busy` drops in the cycle after the last report.
- **Reset:** asynchronous reset in any state returns to IDLE and clears totals, counters, pointer and outputs. An in-flight engine command is abandoned.

## Structure
- **Shared package `md_pkg`:**
  - state enum
  - score width (3), dart width (4), rotation width (3)
  - `MD_BOARD_SIZE=16`
- **Sub-module `md_rr_arbiter`:** combinational masked priority select. Inputs are the eligible vector and the pointer; outputs are the one-hot grant and the index, plus a `found` flag.
- **Top:** holds the FSM, capture registers, counters and totals.

## Test plan
- **Single player:** `NPLAYER=4`, `THROWS=3`, only `req[2]` held, engine returns 5,3,7. Expect no REPORT (others unfinished). Then raise the others, each scoring 1 per throw. Report must be 3,3,15,3.
- **All requesting:** all four `req` held continuously, each throw scores 2. Expect grant order 0,1,2,3 repeated 3 times. Report: four cycles of `out_sum=6` with `out_id` 0..3.
- **Ready stall:** `eng_ready` low for 5 cycles during ISSUE. `eng_valid` and the fields must hold stable for 6 cycles, with exactly one `gnt` pulse.
- **Saturation:** `SUMW=4`, `THROWS=3`, scores 7,7,7. Total must saturate at 15, not wrap to 5.
- **Ignored events:** `start` pulsed mid-game and a stray `eng_done` in ARB. Counters and totals must be unchanged.
- **Reset mid-game:** `rst_n` pulsed low during WAIT. All outputs become 0 immediately. A fresh `start` then replays a clean game with totals from zero.
